uart_host: RTL

Host-side buffer and sequencer for the `uart` block: it drains received bytes through the uart's `cmd_read`/`data_avail`/`bus_out` read port into an RX FIFO, and feeds bytes from a TX FIFO into its `cmd_write`/`busy_write`/`bus_in` write port. It sits between the CPU bus decoder and one `uart` instance and owns every uart command strobe. The CPU sees two valid/ready byte streams instead of raw single-byte uart registers.

---
 rtl/uart_host.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_host.sv
// uart_host: RX/TX byte FIFOs and command sequencer for one uart instance.
// Define UART_HOST_OVERRUN_EN to drain the uart into a full RX FIFO and flag drops.
module uart_host #(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    output logic       u_cmd_read,
    input  logic       u_data_avail,
    input  logic [7:0] u_bus_out,
    output logic       u_cmd_write,
    input  logic       u_busy_write,
    output logic [7:0] u_bus_in,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       overrun,
    input  logic       overrun_clr
);
    localparam int RPW = $clog2(RX_DEPTH);
    localparam int TPW = $clog2(TX_DEPTH);

    typedef logic [RPW-1:0] rptr_t;
    typedef logic [RPW:0]   rcnt_t;
    typedef logic [TPW-1:0] tptr_t;
    typedef logic [TPW:0]   tcnt_t;

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_CAP} r_state_t;
    typedef enum logic [1:0] {T_IDLE, T_ISSUE, T_GUARD} t_state_t;

    logic [7:0] rx_mem [RX_DEPTH];
    rptr_t      rx_wp, rx_rp;
    rcnt_t      rx_cnt;
    logic       rx_full, rx_push, rx_pop, rx_drop;

    logic [7:0] tx_mem [TX_DEPTH];
    tptr_t      tx_wp, tx_rp;
    tcnt_t      tx_cnt;
    logic       tx_push, tx_pop, tx_empty;

    r_state_t   r_state, r_next;
    t_state_t   t_state, t_next;
    logic       cmd_read_d, cmd_write_d, rd_ok;
    logic [7:0] bus_in_d;

    assign rx_full  = rx_cnt == rcnt_t'(RX_DEPTH);
    assign rx_valid = rx_cnt != '0;
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_data  = rx_valid ? rx_mem[rx_rp] : 8'h00;

    assign tx_ready = tx_cnt != tcnt_t'(TX_DEPTH);
    assign tx_empty = tx_cnt == '0;
    assign tx_push  = tx_valid && tx_ready;

`ifdef UART_HOST_OVERRUN_EN
    assign rd_ok = 1'b1;
`else
    assign rd_ok = !rx_full;
`endif

    // RX storage: captured uart bytes land at the write pointer
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= u_bus_out;
    end

    // RX pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + rptr_t'(1);
            if (rx_pop)  rx_rp <= rx_rp + rptr_t'(1);
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + rcnt_t'(1);
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - rcnt_t'(1);
        end
    end

    // TX storage: CPU bytes land at the write pointer
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= tx_data;
    end

    // TX pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + tptr_t'(1);
            if (tx_pop)  tx_rp <= tx_rp + tptr_t'(1);
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + tcnt_t'(1);
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - tcnt_t'(1);
        end
    end

    // Reader: strobe cmd_read, wait a cycle for bus_out, then capture
    always_comb begin
        r_next     = r_state;
        cmd_read_d = 1'b0;
        rx_push    = 1'b0;
        rx_drop    = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (u_data_avail && rd_ok) begin
                    cmd_read_d = 1'b1;
                    r_next     = R_REQ;
                end
            end
            R_REQ: r_next = R_CAP;
            R_CAP: begin
                rx_push = !rx_full;
                rx_drop = rx_full;
                r_next  = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Writer: issue one byte, then guard a cycle so busy_write can rise
    always_comb begin
        t_next      = t_state;
        cmd_write_d = 1'b0;
        bus_in_d    = u_bus_in;
        tx_pop      = 1'b0;
        unique case (t_state)
            T_IDLE: begin
                if (!tx_empty && !u_busy_write) begin
                    bus_in_d    = tx_mem[tx_rp];
                    cmd_write_d = 1'b1;
                    tx_pop      = 1'b1;
                    t_next      = T_ISSUE;
                end
            end
            T_ISSUE: t_next = T_GUARD;
            T_GUARD: t_next = T_IDLE;
            default: t_next = T_IDLE;
        endcase
    end

    // FSM state and registered uart strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= R_IDLE;
            t_state     <= T_IDLE;
            u_cmd_read  <= 1'b0;
            u_cmd_write <= 1'b0;
            u_bus_in    <= 8'h00;
        end else begin
            r_state     <= r_next;
            t_state     <= t_next;
            u_cmd_read  <= cmd_read_d;
            u_cmd_write <= cmd_write_d;
            u_bus_in    <= bus_in_d;
        end
    end

`ifdef UART_HOST_OVERRUN_EN
    // Sticky drop flag; a new drop beats a clear in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           overrun <= 1'b0;
        else if (rx_drop)     overrun <= 1'b1;
        else if (overrun_clr) overrun <= 1'b0;
    end
`else
    logic unused_ok;
    assign overrun   = 1'b0;
    assign unused_ok = overrun_clr | rx_drop;
`endif

endmodule
